// File: rtl/ibex_wb_arbiter.sv
// Writeback-port arbiter: merges LSU load data, ID/EX results and buffered
// multi-cycle FPU results onto one shared integer/FP register-file write port.
// FPU results queue in a small FIFO; a starvation counter forces the FIFO head
// ahead of ID once it has waited long enough.
module ibex_wb_arbiter #(
  parameter int unsigned FpuFifoDepth = 2,
  parameter int unsigned StarveLimit  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        id_we_i,
  input  logic        id_fp_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  output logic        id_ready_o,

  input  logic        lsu_we_i,
  input  logic        lsu_fp_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,

  input  logic        fpu_valid_i,
  input  logic        fpu_fp_i,
  input  logic [4:0]  fpu_waddr_i,
  input  logic [31:0] fpu_wdata_i,
  output logic        fpu_ready_o,

  output logic        rf_we_o,
  output logic        frf_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,

  input  logic [4:0]  hz_raddr_i,
  input  logic        hz_fp_i,
  output logic        hz_o,

  output logic        fpu_pending_o
);

  localparam int unsigned PtrW = $clog2(FpuFifoDepth);
  localparam int unsigned CntW = $clog2(FpuFifoDepth + 1);
  localparam logic [PtrW-1:0] PtrMax    = PtrW'(FpuFifoDepth - 1);
  localparam logic [CntW-1:0] CntFull   = CntW'(FpuFifoDepth);
  localparam logic [3:0]      StarveMax = 4'(StarveLimit);

  // FIFO storage (not reset; validity comes from count_q)
  logic            fifo_fp_q    [FpuFifoDepth];
  logic [4:0]      fifo_waddr_q [FpuFifoDepth];
  logic [31:0]     fifo_wdata_q [FpuFifoDepth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            starve_q, starve_d;

  logic fifo_empty, fifo_full;
  logic lsu_gnt, id_ready, id_gnt, head_gnt, push;
  logic gnt_any, gnt_fp;
  logic hz;

  // Grant decision: LSU > starved head > ID > head; everything gated while in reset
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntFull);
    lsu_gnt    = rst_ni & lsu_we_i;
    id_ready   = rst_ni & ~lsu_we_i & ~starve_q;
    id_gnt     = id_ready & id_we_i;
    // With starve_q set id_ready is low, so the head wins over a waiting ID
    head_gnt   = rst_ni & ~lsu_we_i & ~fifo_empty & ~id_gnt;
    push       = rst_ni & fpu_valid_i & ~fifo_full;
  end

  // Steer the granted source onto the shared write port
  always_comb begin
    gnt_any    = 1'b0;
    gnt_fp     = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    if (lsu_gnt) begin
      gnt_any    = 1'b1;
      gnt_fp     = lsu_fp_i;
      wb_waddr_o = lsu_waddr_i;
      wb_wdata_o = lsu_wdata_i;
    end else if (id_gnt) begin
      gnt_any    = 1'b1;
      gnt_fp     = id_fp_i;
      wb_waddr_o = id_waddr_i;
      wb_wdata_o = id_wdata_i;
    end else if (head_gnt) begin
      gnt_any    = 1'b1;
      gnt_fp     = fifo_fp_q[rd_ptr_q];
      wb_waddr_o = fifo_waddr_q[rd_ptr_q];
      wb_wdata_o = fifo_wdata_q[rd_ptr_q];
    end
    rf_we_o  = gnt_any & ~gnt_fp;
    frf_we_o = gnt_any & gnt_fp;
  end

  // Hazard lookup over registered FIFO entries only (same-cycle push is not visible)
  always_comb begin
    logic [PtrW-1:0] idx;
    hz  = 1'b0;
    idx = '0;
    for (int k = 0; k < int'(FpuFifoDepth); k++) begin
      idx = PtrW'((int'(rd_ptr_q) + k) % int'(FpuFifoDepth));
      if ((k < int'(count_q)) && (fifo_waddr_q[idx] == hz_raddr_i) &&
          (fifo_fp_q[idx] == hz_fp_i)) begin
        hz = 1'b1;
      end
    end
  end

  // Status outputs, forced low during reset
  always_comb begin
    id_ready_o    = id_ready;
    fpu_ready_o   = rst_ni & ~fifo_full;
    fpu_pending_o = rst_ni & ~fifo_empty;
    hz_o          = rst_ni & hz;
  end

  // Next-state: pointers, occupancy and starvation tracking
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_cnt_d = starve_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    if (head_gnt) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !head_gnt) begin
      count_d = count_q + 1'b1;
    end else if (!push && head_gnt) begin
      count_d = count_q - 1'b1;
    end
    if (fifo_empty || head_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starve_d = (starve_cnt_d == StarveMax);
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  // FIFO entry write on push
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_fp_q[wr_ptr_q]    <= fpu_fp_i;
      fifo_waddr_q[wr_ptr_q] <= fpu_waddr_i;
      fifo_wdata_q[wr_ptr_q] <= fpu_wdata_i;
    end
  end

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Self-checking bench for ibex_wb_arbiter: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_ibex_wb_arbiter;

  localparam int Depth     = 2;
  localparam int StarveLim = 4;

  logic        clk;
  logic        rst_n;
  logic        id_we, id_fp, lsu_we, lsu_fp, fpu_valid, fpu_fp, hz_fp;
  logic [4:0]  id_waddr, lsu_waddr, fpu_waddr, hz_raddr;
  logic [31:0] id_wdata, lsu_wdata, fpu_wdata;
  logic        id_ready_o, fpu_ready_o, rf_we_o, frf_we_o, hz_o, fpu_pending_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  ibex_wb_arbiter #(
    .FpuFifoDepth (Depth),
    .StarveLimit  (StarveLim)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .id_we_i       (id_we),
    .id_fp_i       (id_fp),
    .id_waddr_i    (id_waddr),
    .id_wdata_i    (id_wdata),
    .id_ready_o    (id_ready_o),
    .lsu_we_i      (lsu_we),
    .lsu_fp_i      (lsu_fp),
    .lsu_waddr_i   (lsu_waddr),
    .lsu_wdata_i   (lsu_wdata),
    .fpu_valid_i   (fpu_valid),
    .fpu_fp_i      (fpu_fp),
    .fpu_waddr_i   (fpu_waddr),
    .fpu_wdata_i   (fpu_wdata),
    .fpu_ready_o   (fpu_ready_o),
    .rf_we_o       (rf_we_o),
    .frf_we_o      (frf_we_o),
    .wb_waddr_o    (wb_waddr_o),
    .wb_wdata_o    (wb_wdata_o),
    .hz_raddr_i    (hz_raddr),
    .hz_fp_i       (hz_fp),
    .hz_o          (hz_o),
    .fpu_pending_o (fpu_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [42:0] obs = {rf_we_o, frf_we_o, wb_waddr_o, wb_wdata_o,
                     id_ready_o, fpu_ready_o, hz_o, fpu_pending_o};

  typedef struct packed {
    logic        fp;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ent_t;

  ent_t        q[$];
  int          scnt;
  logic [42:0] exp_v;
  bit          m_head_gnt, m_push;
  int          checks = 0;
  int          passed = 0;

  // Expected outputs for the current inputs, from the queue and starve count
  task automatic model_eval();
    bit          starved, pend, hz, we_rf, we_frf;
    logic [4:0]  a;
    logic [31:0] d;
    m_head_gnt = 0;
    m_push     = 0;
    if (!rst_n) begin
      exp_v = '0;
      return;
    end
    pend    = (q.size() != 0);
    starved = (scnt == StarveLim);
    hz = 0;
    foreach (q[i]) if (q[i].waddr == hz_raddr && q[i].fp == hz_fp) hz = 1;
    we_rf = 0; we_frf = 0; a = '0; d = '0;
    if (lsu_we) begin
      we_rf = !lsu_fp; we_frf = lsu_fp; a = lsu_waddr; d = lsu_wdata;
    end else if (starved) begin
      m_head_gnt = 1;
    end else if (id_we) begin
      we_rf = !id_fp; we_frf = id_fp; a = id_waddr; d = id_wdata;
    end else if (pend) begin
      m_head_gnt = 1;
    end
    if (m_head_gnt) begin
      we_rf = !q[0].fp; we_frf = q[0].fp; a = q[0].waddr; d = q[0].wdata;
    end
    m_push = fpu_valid && (q.size() < Depth);
    exp_v = {we_rf, we_frf, a, d, !lsu_we && !starved, q.size() < Depth, hz, pend};
  endtask

  // Model state update at the clock edge
  task automatic model_commit();
    bit   was_empty;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      scnt = 0;
      return;
    end
    was_empty = (q.size() == 0);
    if (m_head_gnt) void'(q.pop_front());
    if (m_push) begin
      e = {fpu_fp, fpu_waddr, fpu_wdata};
      q.push_back(e);
    end
    if (was_empty || m_head_gnt) scnt = 0;
    else if (scnt < StarveLim) scnt++;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_we = 0; id_fp = 0; id_waddr = '0; id_wdata = '0;
    lsu_we = 0; lsu_fp = 0; lsu_waddr = '0; lsu_wdata = '0;
    fpu_valid = 0; fpu_fp = 0; fpu_waddr = '0; fpu_wdata = '0;
    hz_raddr = '0; hz_fp = 0;
  endtask

  task automatic rand_inputs();
    id_we     = ($urandom_range(99) < 60);
    id_fp     = $urandom_range(1);
    id_waddr  = 5'($urandom_range(31));
    id_wdata  = $urandom;
    lsu_we    = ($urandom_range(99) < 30);
    lsu_fp    = $urandom_range(1);
    lsu_waddr = 5'($urandom_range(31));
    lsu_wdata = $urandom;
    fpu_valid = ($urandom_range(99) < 40);
    fpu_fp    = $urandom_range(1);
    fpu_waddr = 5'($urandom_range(7));
    fpu_wdata = $urandom;
    hz_raddr  = 5'($urandom_range(7));
    hz_fp     = $urandom_range(1);
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      settle();
      checks++;
      if (obs !== exp_v || {rf_we_o, frf_we_o, id_ready_o, fpu_ready_o, hz_o,
                            fpu_pending_o} !== 6'b0)
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      advance();
    end
    rst_n = 1;
    idle_inputs();
    settle();
    checks++;
    if (obs !== exp_v || fpu_ready_o !== 1'b1 || fpu_pending_o !== 1'b0)
      $display("FAIL reset_exit got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
  endtask

  task automatic test_lsu_id_conflict();
    idle_inputs();
    lsu_we = 1; lsu_waddr = 5'd5; lsu_wdata = 32'hA5A5_0000;
    id_we = 1; id_waddr = 5'd6; id_wdata = 32'h0000_1234;
    settle();
    checks++;
    if (obs !== exp_v || rf_we_o !== 1'b1 || wb_waddr_o !== 5'd5 || id_ready_o !== 1'b0)
      $display("FAIL lsu_over_id got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
    lsu_we = 0;
    settle();
    checks++;
    if (obs !== exp_v || rf_we_o !== 1'b1 || wb_waddr_o !== 5'd6 || id_ready_o !== 1'b1)
      $display("FAIL id_after_lsu got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
  endtask

  task automatic test_fpu_push();
    idle_inputs();
    fpu_valid = 1; fpu_fp = 1; fpu_waddr = 5'd3; fpu_wdata = 32'h3F80_0000;
    settle();
    checks++;
    if (obs !== exp_v || frf_we_o !== 1'b0 || fpu_pending_o !== 1'b0)
      $display("FAIL fpu_no_bypass got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
    fpu_valid = 0;
    settle();
    checks++;
    if (obs !== exp_v || frf_we_o !== 1'b1 || wb_waddr_o !== 5'd3 ||
        wb_wdata_o !== 32'h3F80_0000 || fpu_pending_o !== 1'b1)
      $display("FAIL fpu_write got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
    settle();
    checks++;
    if (obs !== exp_v || fpu_pending_o !== 1'b0 || frf_we_o !== 1'b0)
      $display("FAIL fpu_drained got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
  endtask

  task automatic test_starve();
    idle_inputs();
    id_we = 1; id_fp = 0;
    for (int c = 0; c < 9; c++) begin
      id_waddr  = 5'($urandom_range(16, 31));
      id_wdata  = $urandom;
      fpu_valid = (c < 2);
      fpu_fp    = 0;
      fpu_waddr = (c == 0) ? 5'd9 : 5'd10;
      fpu_wdata = $urandom;
      settle();
      checks++;
      if (obs !== exp_v) $display("FAIL starve cyc%0d got=%h exp=%h", c, obs, exp_v);
      else passed++;
      if (c == 2) begin
        checks++;
        if (fpu_ready_o !== 1'b0) $display("FAIL starve_full got=%b exp=0", fpu_ready_o);
        else passed++;
      end
      if (c == 5) begin
        checks++;
        if (id_ready_o !== 1'b0 || rf_we_o !== 1'b1 || wb_waddr_o !== 5'd9)
          $display("FAIL starve_head got=%b/%0d exp=0/9", id_ready_o, wb_waddr_o);
        else passed++;
      end
      if (c == 6) begin
        checks++;
        if (id_ready_o !== 1'b1 || wb_waddr_o !== id_waddr)
          $display("FAIL starve_resume got=%b/%0d exp=1/%0d", id_ready_o, wb_waddr_o,
                   id_waddr);
        else passed++;
      end
      advance();
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      settle();
      advance();
    end
  endtask

  task automatic test_hazard();
    idle_inputs();
    lsu_we = 1; lsu_waddr = 5'd1;
    fpu_valid = 1; fpu_fp = 1; fpu_waddr = 5'd7; fpu_wdata = 32'h4000_0000;
    hz_raddr = 5'd7; hz_fp = 1;
    settle();
    checks++;
    if (obs !== exp_v || hz_o !== 1'b0) $display("FAIL hz_push_cycle got=%b exp=0", hz_o);
    else passed++;
    advance();
    fpu_valid = 0;
    settle();
    checks++;
    if (obs !== exp_v || hz_o !== 1'b1) $display("FAIL hz_match got=%b exp=1", hz_o);
    else passed++;
    hz_fp = 0;
    settle();
    checks++;
    if (obs !== exp_v || hz_o !== 1'b0) $display("FAIL hz_fp_mismatch got=%b exp=0", hz_o);
    else passed++;
    advance();
    lsu_we = 0; hz_fp = 1;
    settle();
    advance();
    settle();
    checks++;
    if (obs !== exp_v || hz_o !== 1'b0) $display("FAIL hz_after_drain got=%b exp=0", hz_o);
    else passed++;
    advance();
  endtask

  task automatic test_lsu_flood();
    idle_inputs();
    lsu_we = 1;
    fpu_valid = 1; fpu_fp = 1; fpu_waddr = 5'd12; fpu_wdata = 32'hCAFE_0012;
    for (int c = 0; c < 11; c++) begin
      lsu_fp    = $urandom_range(1);
      lsu_waddr = 5'($urandom_range(31));
      lsu_wdata = $urandom;
      id_we     = $urandom_range(1);
      settle();
      checks++;
      if (obs !== exp_v || wb_waddr_o !== lsu_waddr || (c > 0 && fpu_pending_o !== 1'b1))
        $display("FAIL lsu_flood cyc%0d got=%h exp=%h", c, obs, exp_v);
      else passed++;
      advance();
      fpu_valid = 0;
    end
    idle_inputs();
    settle();
    checks++;
    if (obs !== exp_v || frf_we_o !== 1'b1 || wb_waddr_o !== 5'd12)
      $display("FAIL flood_drain got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    lsu_we = 1;
    fpu_valid = 1; fpu_fp = 0;
    for (int c = 0; c < 2; c++) begin
      fpu_waddr = 5'(20 + c);
      settle();
      advance();
    end
    fpu_valid = 0;
    rst_n = 0;
    settle();
    checks++;
    if (obs !== exp_v) $display("FAIL reset_mid_hold got=%h exp=%h", obs, exp_v);
    else passed++;
    advance();
    rst_n = 1;
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (obs !== exp_v || fpu_pending_o !== 1'b0 || fpu_ready_o !== 1'b1 ||
          rf_we_o !== 1'b0 || frf_we_o !== 1'b0)
        $display("FAIL reset_mid_clear cyc%0d got=%h exp=%h", c, obs, exp_v);
      else passed++;
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      rst_n = ($urandom_range(99) >= 2);
      settle();
      checks++;
      if (obs !== exp_v) $display("FAIL random cyc%0d got=%h exp=%h", c, obs, exp_v);
      else passed++;
      advance();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    scnt  = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_lsu_id_conflict();
    test_fpu_push();
    test_starve();
    test_hazard();
    test_lsu_flood();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
